soc_bus_master: RTL
===================

// Module: soc_bus_master
// PURPOSE
//  Initiator side of the SoC peripheral bus (addr/wdata/we/rdata); peripherals such as the GPIO at 0x30 are responders.
//  Accepts commands over a valid/ready port and turns each into timed bus cycles: WRITE, READ or READ-MODIFY-WRITE.
//  Samples read data and returns one response per command over a valid/ready port.
//  Sits between a test/CPU-side command source and the SoC address decoder.
// PARAMETERS
//  RD_LAT  1  bus cycles between presenting bus_addr and sampling bus_rdata (0..3; 0 = same-cycle sample)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   command accepted when cmd_valid & cmd_ready
//  cmd_op     in   2   00 WRITE, 01 READ, 10 RMW, 11 reserved
//  cmd_addr   in   32  byte address; must be word-aligned
//  cmd_wdata  in   32  write data
//  cmd_mask   in   32  RMW bit mask (1 = take cmd_wdata bit); ignored otherwise
//  rsp_valid  out  1   response present; held until rsp_ready
//  rsp_ready  in   1   response consumed when rsp_valid & rsp_ready
//  rsp_rdata  out  32  READ/RMW: value read from the bus; WRITE/error: 0
//  rsp_err    out  1   1 = misaligned address or reserved op
//  bus_addr   out  32  bus address
//  bus_wdata  out  32  bus write data
//  bus_we     out  1   bus write strobe; exactly one cycle per write
//  bus_rdata  in   32  bus read data from the decoder
// BEHAVIOUR
//  - Reset (sync, at the edge with rst=1): state IDLE; all outputs 0, including cmd_ready while rst=1.
//    cmd_ready=1 in the first cycle after rst drops.
//    Reset mid-transaction aborts it: no further bus_we, and the response is dropped.
//  - States: IDLE, RD, WR, RESP. cmd_ready = (state==IDLE) & ~rst. One command in flight; no overlap with RESP.
//  - Accept in cycle N: latch op/addr/wdata/mask.
//    If addr[1:0]!=0 or op==11: go to RESP with err=1 and rdata=0; no bus activity. rsp_valid is high at N+1.
//  - WRITE: WR in N+1 drives bus_addr and bus_wdata with bus_we=1; then RESP. rsp_valid is high at N+2 with rdata=0.
//  - READ: RD for RD_LAT+1 cycles with bus_addr driven and bus_we=0.
//    A down-counter loaded with RD_LAT; bus_rdata is sampled when the counter reaches 0.
//    Then RESP; rsp_valid is high at N+2+RD_LAT.
//  - RMW: RD phase as in READ, then WR with bus_wdata = (rd & ~mask) | (wdata & mask).
//    rsp_rdata = old value read; rsp_valid is high at N+3+RD_LAT.
//  - Outside RD/WR: bus_addr=0, bus_wdata=0, bus_we=0. All bus outputs are registered (glitch-free).
//  - RESP: rsp_valid=1 with rsp_rdata and rsp_err stable until rsp_ready.
//    The handshake returns to IDLE next cycle; cmd_ready=1 that cycle. rsp_ready=1 already at RESP entry gives a 1-cycle RESP.
//  - rsp_ready while not rsp_valid: ignored. cmd_valid outside IDLE: ignored; the command is not consumed.
//  - Arithmetic: the RD_LAT counter is 2 bits wide; no address increment or wrap (single-beat only).
// STRUCTURE
//  - Package soc_bus_pkg: OP_WRITE/OP_READ/OP_RMW/OP_RSVD encodings, state enum, GPIO_ADDR=32'h30, BUS_AW/BUS_DW=32.
//  - Single module. No sub-module; the latency counter and the RMW merge are inline.
// TESTING (bench: register model at 0x30 holding 8 bits, other addresses read 0, RD_LAT=1)
//  1. WRITE 0x30, 0x000000A5 -> bus_we high one cycle at N+1 with addr 0x30 and wdata 0xA5; rsp_valid at N+2 with rdata 0, err 0.
//  2. READ 0x30 after step 1 -> bus_we never high; rsp_valid at N+3 with rdata 0x000000A5; READ 0x40 -> rdata 0.
//  3. RMW 0x30, wdata 0x0F, mask 0x0F, starting from 0xA5 -> bus_wdata 0xAF written; rsp_rdata 0xA5; a later READ returns 0xAF.
//  4. Errors: cmd_addr 0x31, or op 11 -> rsp_err=1, rdata 0, rsp_valid at N+1, no bus_we or bus_addr activity.
//  5. Backpressure: rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable, cmd_ready=0, a queued cmd_valid is not accepted.
//  6. rst pulsed during the RD phase of an RMW -> no bus_we ever issued, all outputs 0, cmd_ready=1 the cycle after rst drops.

Source files
------------

// File: rtl/soc_bus_pkg.sv
// Shared definitions for the SoC peripheral-bus initiator.
//   - command opcode encodings
//   - initiator FSM state type
//   - bus widths and the well-known GPIO responder address
//   - the read-modify-write merge helper
package soc_bus_pkg;

  localparam int unsigned BUS_AW = 32;
  localparam int unsigned BUS_DW = 32;

  localparam logic [BUS_AW-1:0] GPIO_ADDR = 32'h0000_0030;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_RMW   = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StResp
  } state_e;

  // Mask bit 1 takes the new data bit, mask bit 0 keeps the bit read from the bus.
  function automatic logic [BUS_DW-1:0] rmw_merge(input logic [BUS_DW-1:0] old_data,
                                                   input logic [BUS_DW-1:0] new_data,
                                                   input logic [BUS_DW-1:0] mask);
    return (old_data & ~mask) | (new_data & mask);
  endfunction

endpackage

// File: rtl/soc_bus_master.sv
// Initiator side of the SoC peripheral bus. Takes one command at a time over a
// valid/ready port, runs it as WRITE, READ or READ-MODIFY-WRITE bus cycles and
// returns one response per command over a valid/ready port.
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_op/addr/wdata/mask carry the command
//   rsp_valid/ready     response handshake; rsp_rdata/rsp_err carry the response
//   bus_addr/wdata/we   registered bus outputs (zero outside bus cycles)
//   bus_rdata           read data returned by the address decoder
module soc_bus_master
  import soc_bus_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [BUS_AW-1:0] cmd_addr,
  input  logic [BUS_DW-1:0] cmd_wdata,
  input  logic [BUS_DW-1:0] cmd_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [BUS_DW-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [BUS_AW-1:0] bus_addr,
  output logic [BUS_DW-1:0] bus_wdata,
  output logic              bus_we,
  input  logic [BUS_DW-1:0] bus_rdata
);

  localparam logic [1:0] RdLatInit = RD_LAT[1:0];

  state_e            r_state, w_state_d;
  logic [1:0]        r_op, w_op_d;
  logic [BUS_AW-1:0] r_addr, w_addr_d;
  logic [BUS_DW-1:0] r_wdata, w_wdata_d;
  logic [BUS_DW-1:0] r_mask, w_mask_d;
  logic [1:0]        r_cnt, w_cnt_d;
  logic [BUS_DW-1:0] r_rdata, w_rdata_d;
  logic              r_err, w_err_d;
  logic [BUS_AW-1:0] r_bus_addr, w_bus_addr_d;
  logic [BUS_DW-1:0] r_bus_wdata, w_bus_wdata_d;
  logic              r_bus_we, w_bus_we_d;

  logic w_cmd_bad;

  assign w_cmd_bad = (cmd_addr[1:0] != 2'b00) || (cmd_op == OP_RSVD);

  always_comb begin
    w_state_d = r_state;
    w_op_d    = r_op;
    w_addr_d  = r_addr;
    w_wdata_d = r_wdata;
    w_mask_d  = r_mask;
    w_cnt_d   = r_cnt;
    w_rdata_d = r_rdata;
    w_err_d   = r_err;

    unique case (r_state)
      StIdle: begin
        if (cmd_valid) begin
          w_op_d    = cmd_op;
          w_addr_d  = cmd_addr;
          w_wdata_d = cmd_wdata;
          w_mask_d  = cmd_mask;
          w_cnt_d   = RdLatInit;
          w_rdata_d = '0;
          w_err_d   = w_cmd_bad;
          if (w_cmd_bad) begin
            w_state_d = StResp;
          end else if (cmd_op == OP_WRITE) begin
            w_state_d = StWr;
          end else begin
            w_state_d = StRd;
          end
        end
      end
      StRd: begin
        if (r_cnt == 2'd0) begin
          w_rdata_d = bus_rdata;
          w_state_d = (r_op == OP_RMW) ? StWr : StResp;
        end else begin
          w_cnt_d = r_cnt - 2'd1;
        end
      end
      StWr: begin
        w_state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Bus outputs are registered from the next state so they line up with the
  // RD/WR cycles themselves. For RMW the merge uses the data being sampled now.
  always_comb begin
    w_bus_addr_d  = '0;
    w_bus_wdata_d = '0;
    w_bus_we_d    = 1'b0;
    if ((w_state_d == StRd) || (w_state_d == StWr)) begin
      w_bus_addr_d = w_addr_d;
    end
    if (w_state_d == StWr) begin
      w_bus_we_d    = 1'b1;
      w_bus_wdata_d = (w_op_d == OP_RMW) ? rmw_merge(w_rdata_d, w_wdata_d, w_mask_d)
                                         : w_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_op        <= OP_WRITE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mask      <= '0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_we    <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_op        <= w_op_d;
      r_addr      <= w_addr_d;
      r_wdata     <= w_wdata_d;
      r_mask      <= w_mask_d;
      r_cnt       <= w_cnt_d;
      r_rdata     <= w_rdata_d;
      r_err       <= w_err_d;
      r_bus_addr  <= w_bus_addr_d;
      r_bus_wdata <= w_bus_wdata_d;
      r_bus_we    <= w_bus_we_d;
    end
  end

  assign cmd_ready = (r_state == StIdle) && !rst;
  assign rsp_valid = (r_state == StResp);
  // Response fields read as zero whenever no response is being offered.
  assign rsp_rdata = rsp_valid ? r_rdata : '0;
  assign rsp_err   = rsp_valid ? r_err : 1'b0;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_we    = r_bus_we;

endmodule
